uart_rx: RTL

UART receiver that pairs with the existing uart_tx. It uses the same framing: 1 start bit, 8 data bits LSB first, optional parity bit, and 1 stop bit. It uses the same bit timing as uart_tx. It sits between the external RX pin and the byte consumer, delivering each received byte with a one-cycle valid strobe and per-frame error flags.

---
 rtl/uart_rx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit.
// Mid-bit sampling on a synchronized copy of the RX line; per-frame error flags.
module uart_rx #(
  parameter int unsigned CLOCK_FREQ_Mhz = 12,
  parameter int unsigned BAUD_RATE      = 9600,
  parameter logic [1:0]  PARITY_MODE    = 2'b00
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Data,
  output logic [7:0] o_Data,
  output logic       o_Valid,
  output logic       o_Parity_Err,
  output logic       o_Frame_Err,
  output logic       o_Idle
);

  localparam int unsigned COUNTER_LIMIT = (CLOCK_FREQ_Mhz * 1_000_000) / BAUD_RATE;
  localparam int unsigned CNT_W         = $clog2(COUNTER_LIMIT + 1);
  localparam int unsigned HALF          = COUNTER_LIMIT / 2;
  localparam logic [CNT_W-1:0] LIMIT_C  = CNT_W'(COUNTER_LIMIT);
  localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(HALF);
  // Mode 2'b11 is treated as no parity.
  localparam bit PARITY_EN = (PARITY_MODE == 2'b01) || (PARITY_MODE == 2'b10);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             par_err_q;
  logic             rx_meta_q;
  logic             rx_s_q;

  // Two-flop synchronizer; preset high so reset looks like an idle line.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_Data;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM with registered byte, strobe and error flags.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      o_Data       <= '0;
      o_Valid      <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Idle       <= 1'b1;
    end else begin
      o_Valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          o_Idle <= 1'b1;
          if (!rx_s_q) begin
            cnt_q   <= '0;
            o_Idle  <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == HALF_C) begin
            if (!rx_s_q) begin
              cnt_q     <= '0;
              bit_cnt_q <= '0;
              state_q   <= S_DATA;
            end else begin
              // False start: drop back without touching data or flags.
              o_Idle  <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == LIMIT_C) begin
            shift_q[bit_cnt_q] <= rx_s_q;
            cnt_q              <= '0;
            if (bit_cnt_q == 3'd7) begin
              state_q <= PARITY_EN ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (cnt_q == LIMIT_C) begin
            par_err_q <= ((^shift_q) ^ PARITY_MODE[0]) != rx_s_q;
            cnt_q     <= '0;
            state_q   <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == LIMIT_C) begin
            o_Data       <= shift_q;
            o_Parity_Err <= PARITY_EN ? par_err_q : 1'b0;
            o_Frame_Err  <= ~rx_s_q;
            o_Valid      <= 1'b1;
            cnt_q        <= '0;
            if (rx_s_q) begin
              o_Idle  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              // Line held low past the stop bit: wait for release before re-arming.
              state_q <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_BREAK: begin
          if (rx_s_q) begin
            o_Idle  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          o_Idle  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
